// File: rtl/wave_synth_pkg.sv
// Shared types and constants for the tone generator: envelope states,
// waveform select codes and amplitude limits.
package wave_synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_MUTE   = 2'd3;

  localparam logic signed [15:0] SQUARE_AMP = 16'sh7FFF;
  localparam logic [7:0]         ENV_MAX    = 8'd255;

endpackage

// File: rtl/period_recip_div.sv
// Sequential reciprocal: quotient = floor(2^32 / divisor), one quotient bit per clk.
// Divisors below 2 produce a zero quotient without iterating.
module period_recip_div
  import wave_synth_pkg::*;
#(
  parameter int w_period = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [w_period-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [31:0]         quotient
);

  logic [w_period-1:0] div_reg;
  logic [w_period-1:0] rem_reg;
  logic [31:0]         num_reg;
  logic [5:0]          count_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [w_period:0]   rem_shift;
  logic [w_period-1:0] rem_diff;
  logic                fits;

  // The dividend is a single 1 above 32 zeros: its top bit seeds the remainder
  // and only zeros are brought down afterwards.
  always_comb begin
    rem_shift = {rem_reg, 1'b0};
    fits      = (rem_shift >= {1'b0, div_reg});
    rem_diff  = rem_shift[w_period-1:0] - div_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg   <= '0;
      rem_reg   <= '0;
      num_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        div_reg   <= divisor;
        rem_reg   <= w_period'(1);
        num_reg   <= '0;
        count_reg <= 6'd32;
        if (divisor < w_period'(2)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          busy_reg <= 1'b1;
        end
      end else if (busy_reg) begin
        rem_reg   <= fits ? rem_diff : rem_shift[w_period-1:0];
        num_reg   <= {num_reg[30:0], fits};
        count_reg <= count_reg - 6'd1;
        if (count_reg == 6'd1) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = num_reg;

endmodule

// File: rtl/wave_period_synth.sv
// Period-driven tone generator: phase accumulator, square/saw/triangle shaping,
// attack/sustain/release envelope, and a neg->pos zero-crossing pulse.
module wave_period_synth
  import wave_synth_pkg::*;
#(
  parameter int w_period        = 20,
  parameter int w_sound         = 16,
  parameter int env_step_cycles = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gate,
  input  logic [w_period-1:0]        period,
  input  logic [1:0]                 wave_sel,
  input  logic [2:0]                 amp_shift,
  output logic signed [w_sound-1:0]  sound,
  output logic                       zero_cross,
  output env_state_t                 env_state,
  output logic [7:0]                 env_level
);

  localparam int TICK_W = (env_step_cycles > 1) ? $clog2(env_step_cycles) : 1;

  logic [w_period-1:0] req_period_reg;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [31:0]         div_quot;

  logic [31:0] next_step_reg;
  logic [31:0] step_reg;
  logic [31:0] acc_reg;
  logic [31:0] step_src;
  logic [32:0] acc_sum;
  logic        step_load;

  env_state_t        state_reg;
  env_state_t        state_next;
  logic [7:0]        level_reg;
  logic [7:0]        level_next;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;

  logic signed [15:0]        wave;
  logic signed [24:0]        prod;
  logic signed [15:0]        scaled;
  logic signed [w_sound-1:0] sound_reg;
  logic                      zero_cross_reg;
  logic                      unused_prod_bits;

  // Only one divide in flight; a change arriving mid-divide is picked up once it finishes.
  assign div_start = (period != req_period_reg) && !div_busy;

  period_recip_div #(
    .w_period(w_period)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .divisor (period),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quot)
  );

  // Step changes only at a phase wrap, so a period change never jumps the phase.
  always_comb begin
    acc_sum   = {1'b0, acc_reg} + {1'b0, step_reg};
    step_src  = div_done ? div_quot : next_step_reg;
    step_load = acc_sum[32] || (step_reg == 32'd0) || (state_reg == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_period_reg <= '0;
      next_step_reg  <= '0;
      step_reg       <= '0;
      acc_reg        <= '0;
    end else begin
      if (div_start) req_period_reg <= period;
      if (div_done)  next_step_reg  <= div_quot;
      if (step_load) step_reg       <= step_src;
      acc_reg <= (state_next == IDLE) ? 32'd0 : acc_sum[31:0];
    end
  end

  assign tick = (state_reg != IDLE) && (tick_cnt_reg == TICK_W'(env_step_cycles - 1));

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (gate) state_next = ATTACK;
      end
      ATTACK: begin
        if (!gate)                    state_next = RELEASE;
        else if (level_reg == ENV_MAX) state_next = SUSTAIN;
        else if (tick)                level_next = level_reg + 8'd1;
      end
      SUSTAIN: begin
        level_next = ENV_MAX;
        if (!gate) state_next = RELEASE;
      end
      RELEASE: begin
        if (gate)                    state_next = ATTACK;
        else if (level_reg == 8'd0)  state_next = IDLE;
        else if (tick)               level_next = level_reg - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      level_reg    <= 8'd0;
      tick_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      if ((state_reg == IDLE) || (state_next != state_reg) || tick)
        tick_cnt_reg <= '0;
      else
        tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  always_comb begin
    wave = 16'sd0;
    case (wave_sel)
      WAVE_SQUARE: wave = acc_reg[31] ? -SQUARE_AMP : SQUARE_AMP;
      WAVE_SAW:    wave = $signed(acc_reg[31:16] ^ 16'h8000);
      WAVE_TRI:    wave = $signed((acc_reg[31] ? ~acc_reg[30:15] : acc_reg[30:15]) ^ 16'h8000);
      default:     wave = 16'sd0;
    endcase
  end

  // Envelope level is unsigned, so it is widened with a zero before the signed multiply.
  always_comb begin
    prod   = 25'(wave) * 25'($signed({1'b0, level_reg}));
    scaled = $signed(prod[23:8]) >>> amp_shift;
  end

  assign unused_prod_bits = ^{prod[24], prod[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sound_reg      <= '0;
      zero_cross_reg <= 1'b0;
    end else begin
      sound_reg      <= scaled;
      zero_cross_reg <= sound_reg[w_sound-1] & ~scaled[15];
    end
  end

  assign sound      = sound_reg;
  assign zero_cross = zero_cross_reg;
  assign env_state  = state_reg;
  assign env_level  = level_reg;

endmodule

// File: tb/tb_wave_period_synth.sv
// Self-checking bench for wave_period_synth: divider vectors, envelope timing,
// zero-crossing spacing and a sample-level model of the wave/scale path.
module tb_wave_period_synth;
  import wave_synth_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              gate;
  logic [19:0]       period;
  logic [1:0]        wave_sel;
  logic [2:0]        amp_shift;
  logic signed [15:0] sound;
  logic              zero_cross;
  env_state_t        env_state;
  logic [7:0]        env_level;

  int tests = 0;
  int fails = 0;

  localparam longint TWO32 = longint'(1) << 32;
  localparam longint TWO31 = longint'(1) << 31;

  typedef struct {
    logic [19:0] per;
    longint      exp_step;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  wave_period_synth #(
    .w_period(20),
    .w_sound(16),
    .env_step_cycles(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gate      (gate),
    .period    (period),
    .wave_sel  (wave_sel),
    .amp_shift (amp_shift),
    .sound     (sound),
    .zero_cross(zero_cross),
    .env_state (env_state),
    .env_level (env_level)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input longint actual, input longint lo, input longint hi);
    tests++;
    if (actual < lo || actual > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic longint recip(input longint p);
    return (p < 2) ? 0 : TWO32 / p;
  endfunction

  function automatic longint fdiv(input longint x, input longint d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  // Sample value implied by a phase, selection, level and attenuation.
  function automatic longint model_sound(input longint acc, input int sel, input int lvl, input int sh);
    longint w;
    longint t;
    case (sel)
      0: w = (acc >= TWO31) ? -32767 : 32767;
      1: w = acc / 65536 - 32768;
      2: begin
        t = (acc % TWO31) / 32768;
        if (acc >= TWO31) t = 65535 - t;
        w = t - 32768;
      end
      default: w = 0;
    endcase
    return fdiv(fdiv(w * lvl, 256), longint'(1) << sh);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic wait_state(input env_state_t s, input int limit, output int n);
    n = 0;
    while (env_state != s && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic measure_spacing(input string name, input int nom, input int pulses);
    int last;
    int n;
    int got;
    last = -1;
    got  = 0;
    n    = 0;
    while (got < pulses && n < 4 * nom * (pulses + 1)) begin
      @(negedge clk);
      n++;
      if (zero_cross) begin
        if (last >= 0) check_range(name, n - last, nom - 1, nom + 1);
        last = n;
        got++;
      end
    end
    check({name, "_pulses"}, got, pulses);
  endtask

  initial begin
    int n;
    int t_step;
    int t_sus;
    int bad;
    int pulses;
    bit changed;
    longint prev_step;
    longint prev_acc;
    longint exp_s;
    longint rec_acc;
    int rec_sel;
    int rec_lvl;
    int rec_sh;
    longint hold_sound;

    vecs[0] = '{20'd1000,    64'd4294967};
    vecs[1] = '{20'd500,     64'd8589934};
    vecs[2] = '{20'd2,       64'd2147483648};
    vecs[3] = '{20'd3,       64'd1431655765};
    vecs[4] = '{20'd7,       64'd613566756};
    vecs[5] = '{20'd1048575, 64'd4096};
    vecs[6] = '{20'd1,       64'd0};
    vecs[7] = '{20'd999999,  64'd4294};

    rst = 1'b1; gate = 1'b0; period = '0; wave_sel = WAVE_SQUARE; amp_shift = 3'd0;
    cycles(3);
    rst = 1'b0;
    check("reset_sound", sound, 0);
    check("reset_zc", zero_cross, 0);
    check("reset_state", env_state, IDLE);
    check("reset_level", env_level, 0);

    // Divider vectors.
    for (int i = 0; i < 8; i++) begin
      period = vecs[i].per;
      cycles(40);
      $display("[TB] vec %0d period=%0d next_step=%0d", i, vecs[i].per, dut.next_step_reg);
      check("div_table", dut.next_step_reg, vecs[i].exp_step);
    end
    for (int i = 0; i < 20; i++) begin
      period = 20'($urandom_range(2, 1048575));
      cycles(40);
      check("div_random", dut.next_step_reg, recip(longint'(period)));
    end
    // Last requested period wins when changes land mid-divide.
    period = 20'd700; cycles(3);
    period = 20'd300; cycles(3);
    period = 20'd900; cycles(80);
    check("div_last_wins", dut.next_step_reg, recip(900));

    // Attack to sustain with period 1000.
    do_reset();
    period = 20'd1000; gate = 1'b1; wave_sel = WAVE_SQUARE; amp_shift = 3'd0;
    t_step = -1; t_sus = -1; n = 0;
    while (t_sus < 0 && n < 1200) begin
      @(negedge clk);
      n++;
      if (t_step < 0 && dut.next_step_reg == 32'd4294967) t_step = n;
      if (env_state == SUSTAIN) t_sus = n;
    end
    check_range("next_step_latency", t_step, 1, 34);
    check_range("attack_time", t_sus, 1015, 1030);
    check("sustain_level", env_level, 255);
    measure_spacing("zc_1000", 1000, 4);

    // Release back to idle.
    gate = 1'b0;
    cycles(1);
    check("release_entry", env_state, RELEASE);
    wait_state(IDLE, 1200, n);
    check_range("release_time", n + 1, 1015, 1030);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sound != 0 || env_level != 0 || zero_cross) bad++;
    end
    check("idle_silent", bad, 0);

    // Period change in sustain: step swaps only at a phase wrap.
    gate = 1'b1;
    wait_state(SUSTAIN, 1200, n);
    check("sustain_again", env_state, SUSTAIN);
    period = 20'd500;
    prev_step = dut.step_reg; prev_acc = dut.acc_reg; changed = 0; n = 0;
    while (!changed && n < 3000) begin
      @(negedge clk);
      n++;
      if (longint'(dut.step_reg) != prev_step) begin
        changed = 1;
        check("step_at_carry", longint'(dut.acc_reg) < prev_acc, 1);
        check("step_500", dut.step_reg, recip(500));
      end
      prev_step = dut.step_reg;
      prev_acc  = dut.acc_reg;
    end
    check("step_changed", changed, 1);
    measure_spacing("zc_500", 500, 3);

    // Reset mid-run with a divide in flight.
    period = 20'd777;
    cycles(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sound", sound, 0);
    check("midrst_zc", zero_cross, 0);
    check("midrst_state", env_state, IDLE);
    check("midrst_level", env_level, 0);
    check("midrst_step", dut.step_reg, 0);
    check("midrst_div_busy", dut.div_busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Silence-period: no phase motion, no crossings.
    gate = 1'b0;
    period = 20'd1;
    cycles(2);
    gate = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (zero_cross) pulses++;
    end
    check("silent_pulses", pulses, 0);
    check("silent_step", dut.step_reg, 0);
    check("silent_state", env_state, SUSTAIN);
    check("silent_sound", sound, model_sound(0, 0, 255, 0));
    hold_sound = sound;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (longint'(sound) != hold_sound || zero_cross) bad++;
    end
    check("silent_constant", bad, 0);

    // Attack with randomized shape/attenuation checked per sample, then a gate blip at level 100.
    do_reset();
    period = 20'd1000; gate = 1'b1;
    rec_acc = -1; rec_sel = 0; rec_lvl = 0; rec_sh = 0; n = 0;
    while (env_level != 8'd100 && n < 600) begin
      @(negedge clk);
      n++;
      if (rec_acc >= 0) begin
        exp_s = model_sound(rec_acc, rec_sel, rec_lvl, rec_sh);
        check("wave_model", sound, exp_s);
      end
      wave_sel  = 2'($urandom_range(0, 3));
      amp_shift = 3'($urandom_range(0, 7));
      rec_acc = dut.acc_reg;
      rec_sel = wave_sel;
      rec_lvl = env_level;
      rec_sh  = amp_shift;
    end
    check("reach_level_100", env_level, 100);
    gate = 1'b0;
    cycles(1);
    check("blip_release", env_state, RELEASE);
    cycles(5);
    gate = 1'b1;
    cycles(1);
    check("blip_attack", env_state, ATTACK);
    check_range("blip_level", env_level, 98, 100);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (env_level < 8'd98) bad++;
    end
    check("blip_no_drop", bad, 0);
    check_range("blip_resumes", env_level, 100, 112);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
